// File: rtl/divided_signal_generator.sv
// Purpose : source of the divided-signal pipeline path; produces 1/2-rate and 1/4-rate
//           divided signals plus one-cycle pipe enables, with a start/stop handshake that
//           drains until both divided signals are low.
// Latency : start edge E0 -> first one_half toggle on edge E0+prescale_q+1; all outputs registered.
// Backpressure: none; stop is a request that completes after at most 4 ticks (busy tracks it).
// Ports:
//   clock, reset (sync, active-high) | start, stop, prescale (latched on start)
//   busy | signal_from_one_half + one_half_pipe_enable | signal_from_one_forth +
//   one_forth_pipe_enable | half_toggle_count (one_half toggles since start, wraps)
module divided_signal_generator #(
  parameter int PRESC_WIDTH      = 8,
  parameter int COUNT_WIDTH      = 16,
  parameter int ONE_FORTH_ENABLE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic                   busy,
  output logic                   signal_from_one_half,
  output logic                   one_half_pipe_enable,
  output logic                   signal_from_one_forth,
  output logic                   one_forth_pipe_enable,
  output logic [COUNT_WIDTH-1:0] half_toggle_count
);

  localparam bit FORTH_ON = (ONE_FORTH_ENABLE != 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic [PRESC_WIDTH-1:0] prescale_q;
  logic                   phase;      // 1 when the next tick also toggles one_forth

  logic tick;
  logic next_half;
  logic next_forth;
  logic signals_low;
  logic next_low;
  logic draining;

  always_comb begin
    tick        = (state != IDLE) && (presc_cnt == prescale_q);
    next_half   = ~signal_from_one_half;
    next_forth  = FORTH_ON && (phase ? ~signal_from_one_forth : signal_from_one_forth);
    signals_low = ~signal_from_one_half && ~(FORTH_ON && signal_from_one_forth);
    next_low    = ~next_half && ~next_forth;
    // A stop seen in RUN already counts as draining on that same edge, so a tick that
    // lands on the stop edge and brings both signals low finishes the drain immediately.
    draining    = (state == DRAIN) || ((state == RUN) && stop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      busy                  <= 1'b0;
      presc_cnt             <= '0;
      prescale_q            <= '0;
      phase                 <= 1'b0;
      signal_from_one_half  <= 1'b0;
      one_half_pipe_enable  <= 1'b0;
      signal_from_one_forth <= 1'b0;
      one_forth_pipe_enable <= 1'b0;
      half_toggle_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          one_half_pipe_enable  <= 1'b0;
          one_forth_pipe_enable <= 1'b0;
          if (start) begin
            state             <= RUN;
            busy              <= 1'b1;
            prescale_q        <= prescale;
            presc_cnt         <= '0;
            phase             <= 1'b0;
            half_toggle_count <= '0;
          end
        end

        RUN, DRAIN: begin
          if ((state == RUN) && stop && signals_low) begin
            // Already low: stop cleanly without another tick.
            state                 <= IDLE;
            busy                  <= 1'b0;
            presc_cnt             <= '0;
            phase                 <= 1'b0;
            one_half_pipe_enable  <= 1'b0;
            one_forth_pipe_enable <= 1'b0;
          end else begin
            if (tick) begin
              presc_cnt             <= '0;
              signal_from_one_half  <= next_half;
              one_half_pipe_enable  <= 1'b1;
              signal_from_one_forth <= next_forth;
              one_forth_pipe_enable <= FORTH_ON && phase;
              half_toggle_count     <= half_toggle_count + COUNT_WIDTH'(1);
              phase                 <= ~phase;
            end else begin
              presc_cnt             <= presc_cnt + PRESC_WIDTH'(1);
              one_half_pipe_enable  <= 1'b0;
              one_forth_pipe_enable <= 1'b0;
            end

            if (draining && tick && next_low) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (draining) begin
              state <= DRAIN;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divided_signal_generator.sv
// Randomized + scripted stimulus on two instances (full config, and 4-bit count with
// the 1/4 path disabled); expectations from a tick-count reference model feed queues
// that a negedge monitor drains and compares.
module tb_divided_signal_generator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [7:0] prescale = 8'd0;

  logic        busy0, h0, eh0, f0, ef0;
  logic [15:0] cnt0;
  logic        busy1, h1, eh1, f1, ef1;
  logic [3:0]  cnt1;

  always #5 clock = ~clock;

  divided_signal_generator #(.PRESC_WIDTH(8), .COUNT_WIDTH(16), .ONE_FORTH_ENABLE(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .prescale(prescale),
    .busy(busy0), .signal_from_one_half(h0), .one_half_pipe_enable(eh0),
    .signal_from_one_forth(f0), .one_forth_pipe_enable(ef0), .half_toggle_count(cnt0));

  divided_signal_generator #(.PRESC_WIDTH(8), .COUNT_WIDTH(4), .ONE_FORTH_ENABLE(0)) dut1 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .prescale(prescale),
    .busy(busy1), .signal_from_one_half(h1), .one_half_pipe_enable(eh1),
    .signal_from_one_forth(f1), .one_forth_pipe_enable(ef1), .half_toggle_count(cnt1));

  typedef struct {
    int cyc;
    bit busy, h, eh, f, ef;
    int cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: everything follows from k = ticks since start and c = clocks since start.
  // mode: 0 idle, 1 run, 2 drain
  int     m_mode[2];
  longint m_k[2];
  longint m_c[2];
  int     m_p[2];
  bit     m_eh[2];
  bit     m_ef[2];

  function automatic bit is_low(input int d, input longint k);
    return (d == 0) ? (k % 4 == 0) : (k % 2 == 0);
  endfunction

  task automatic model_step(input int d, input bit rst, input bit st, input bit sp,
                            input int pres, output exp_t e);
    bit tick;
    m_eh[d] = 0;
    m_ef[d] = 0;
    if (rst) begin
      m_mode[d] = 0; m_k[d] = 0; m_c[d] = 0; m_p[d] = 0;
    end else if (m_mode[d] == 0) begin
      if (st) begin
        m_mode[d] = 1; m_k[d] = 0; m_c[d] = 0; m_p[d] = pres;
      end
    end else if (m_mode[d] == 1 && sp && is_low(d, m_k[d])) begin
      m_mode[d] = 0;
    end else begin
      m_c[d] = m_c[d] + 1;
      tick = (m_c[d] % (m_p[d] + 1)) == 0;
      if (tick) begin
        m_k[d]  = m_k[d] + 1;
        m_eh[d] = 1;
        m_ef[d] = (d == 0) && (m_k[d] % 2 == 0);
      end
      if (m_mode[d] == 1 && sp) m_mode[d] = 2;
      if (m_mode[d] == 2 && tick && is_low(d, m_k[d])) m_mode[d] = 0;
    end
    e.cyc  = cyc + 1;
    e.busy = (m_mode[d] != 0);
    e.h    = (m_k[d] % 2) == 1;
    e.f    = (d == 0) && (((m_k[d] / 2) % 2) == 1);
    e.eh   = m_eh[d];
    e.ef   = m_ef[d];
    e.cnt  = int'(m_k[d] % ((d == 0) ? 65536 : 16));
  endtask

  task automatic drive(input bit rst, input bit st, input bit sp, input int pres);
    exp_t e;
    reset = rst; start = st; stop = sp; prescale = 8'(pres);
    model_step(0, rst, st, sp, pres, e); q0.push_back(e);
    model_step(1, rst, st, sp, pres, e); q1.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic chk(input string name, input int d, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", name, d, cyc, act, expv);
    end
  endtask

  // Monitor: compares the DUT outputs of each edge against the queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      chk("busy", 0, int'(busy0), int'(e.busy));
      chk("one_half", 0, int'(h0), int'(e.h));
      chk("one_half_en", 0, int'(eh0), int'(e.eh));
      chk("one_forth", 0, int'(f0), int'(e.f));
      chk("one_forth_en", 0, int'(ef0), int'(e.ef));
      chk("count", 0, int'(cnt0), e.cnt);
    end
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      chk("busy", 1, int'(busy1), int'(e.busy));
      chk("one_half", 1, int'(h1), int'(e.h));
      chk("one_half_en", 1, int'(eh1), int'(e.eh));
      chk("one_forth", 1, int'(f1), int'(e.f));
      chk("one_forth_en", 1, int'(ef1), int'(e.ef));
      chk("count", 1, int'(cnt1), e.cnt);
    end
  end

  int pres_r;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_k[d] = 0; m_c[d] = 0; m_p[d] = 0; m_eh[d] = 0; m_ef[d] = 0;
    end
    @(posedge clock); #1;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    // prescale 0 free run, then stop after a single tick
    drive(0, 1, 0, 0);
    repeat (12) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    repeat (6) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    repeat (6) drive(0, 0, 0, 0);
    // start+stop together, prescale 2, then prescale changes and held start while busy
    drive(0, 1, 1, 2);
    repeat (10) drive(0, 1, 0, 5);
    repeat (10) drive(0, 0, 0, 5);
    drive(0, 0, 1, 5);
    repeat (16) drive(0, 0, 0, 5);
    // long prescale 0 run for count wrap, then reset in the middle of a drain
    drive(0, 1, 0, 0);
    repeat (41) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    // stop while already low returns to idle on the next edge
    drive(0, 1, 0, 1);
    drive(0, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 1);
    // randomized traffic
    pres_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) pres_r = int'($urandom_range(0, 4));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, pres_r);
    end
    repeat (4) drive(0, 0, 0, pres_r);
    @(negedge clock);
    @(negedge clock);
    chk("queue0_drained", 0, q0.size(), 0);
    chk("queue1_drained", 1, q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
